// File: rtl/twiddle_mult_sequencer.sv
// Twiddle/bypass sequencer for one radix-2 DIF SDF FFT stage. It indexes the twiddle ROM
// per sample and tracks valid samples through the shared complex multiplier.
`timescale 1ns/1ps
module twiddle_mult_sequencer #(
   parameter int unsigned N_POINTS = 64,
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned STAGE    = 0,
   parameter int unsigned MULT_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              frame_start,
   output logic [ADDR_W-1:0] twid_addr,
   output logic              twid_bypass,
   output logic              twid_en,
   output logic              mult_vld,
   output logic              frame_done,
   output logic              sync_err,
   output logic              busy
);

   localparam int unsigned SPAN    = N_POINTS >> STAGE;
   localparam int unsigned HALF    = SPAN / 2;
   localparam int unsigned SR_W    = MULT_LAT + 1;
   localparam int unsigned DCNT_W  = $clog2(MULT_LAT + 2);

   localparam logic [ADDR_W-1:0] SPAN_MASK  = ADDR_W'(SPAN - 1);
   localparam logic [ADDR_W-1:0] HALF_IDX   = ADDR_W'(HALF);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N_POINTS - 1);
   localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(MULT_LAT);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [DCNT_W-1:0] drain_q;
   logic [SR_W-1:0]   vld_sr;
   logic [SR_W-1:0]   last_sr;

   logic              accept;
   logic              is_last;
   logic              upper;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] pos;
   logic [ADDR_W-1:0] k;
   logic [ADDR_W-1:0] addr_nxt;
   logic              bypass_nxt;

   // A frame_start always restarts numbering at 0, whatever state we are in.
   always_comb begin
      accept     = in_valid && (frame_start || (state_q == StRun));
      idx        = frame_start ? '0 : cnt_q;
      pos        = idx & SPAN_MASK;
      upper      = (pos >= HALF_IDX);
      k          = pos - HALF_IDX;
      addr_nxt   = upper ? (k << STAGE) : '0;
      bypass_nxt = !upper || (k == '0);
      is_last    = (idx == LAST_IDX);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         drain_q     <= '0;
         vld_sr      <= '0;
         last_sr     <= '0;
         twid_addr   <= '0;
         twid_bypass <= 1'b0;
         twid_en     <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         twid_en  <= accept;
         sync_err <= accept && frame_start && (state_q == StRun) && (cnt_q != '0);
         // Tag bits ride alongside the data through the ROM register and the multiplier.
         vld_sr   <= (vld_sr << 1) | SR_W'(accept);
         last_sr  <= (last_sr << 1) | SR_W'(accept && is_last);

         if (accept) begin
            twid_addr   <= addr_nxt;
            twid_bypass <= bypass_nxt;
            cnt_q       <= is_last ? idx : idx + ADDR_W'(1);
            drain_q     <= '0;
            state_q     <= is_last ? StDrain : StRun;
         end else if (state_q == StDrain) begin
            if (drain_q == DRAIN_LAST) begin
               state_q <= StIdle;
            end else begin
               drain_q <= drain_q + DCNT_W'(1);
            end
         end
      end
   end

   assign mult_vld   = vld_sr[MULT_LAT];
   assign frame_done = last_sr[MULT_LAT];
   assign busy       = (state_q != StIdle);

endmodule
